// File: rtl/operand_fetch_if.sv
// Bundle of decoded-instruction input, register-file read, write-back and
// operand output signals for the operand_fetch stage.
interface operand_fetch_if #(parameter int pw = 4);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [pw:0]   in_rs_a;
  logic [pw:0]   in_rs_b;
  logic [pw:0]   in_rd;
  logic          in_wr_en;
  logic [pw:0]   rf_rd_addrA;
  logic [pw:0]   rf_rd_addrB;
  logic [7:0]    rf_datA;
  logic [7:0]    rf_datB;
  logic          wb_en;
  logic [pw:0]   wb_addr;
  logic [7:0]    wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_op;
  logic [7:0]    out_opA;
  logic [7:0]    out_opB;
  logic [pw:0]   out_rd;
  logic          out_wr_en;
  logic [7:0]    stall_cnt;

  // Handshake: a side transfers when valid && ready at a rising clk edge;
  // in_valid may depend on in_ready, in_ready never depends on in_valid.
  modport master (
    output in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_wr_en,
    input  in_ready,
    input  rf_rd_addrA, rf_rd_addrB,
    output rf_datA, rf_datB,
    output wb_en, wb_addr, wb_data,
    input  out_valid, out_op, out_opA, out_opB, out_rd, out_wr_en,
    output out_ready,
    input  stall_cnt
  );

  modport slave (
    input  in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_wr_en,
    output in_ready,
    output rf_rd_addrA, rf_rd_addrB,
    input  rf_datA, rf_datB,
    input  wb_en, wb_addr, wb_data,
    output out_valid, out_op, out_opA, out_opB, out_rd, out_wr_en,
    input  out_ready,
    output stall_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, tracks pending writes in a
// busy scoreboard, bypasses same-cycle write-back data, one-deep output register.
module operand_fetch #(
    parameter int pw = 4
) (
    input logic              clk,
    input logic              rst_n,
    operand_fetch_if.slave   bus
);
    localparam int depth = 1 << pw;

    logic [depth-1:0] busy;
    logic [depth-1:0] busy_nxt;
    logic             out_valid_q;
    logic [3:0]       out_op_q;
    logic [7:0]       out_opa_q;
    logic [7:0]       out_opb_q;
    logic [pw:0]      out_rd_q;
    logic             out_wr_en_q;
    logic [7:0]       stall_q;

    logic [pw-1:0]    rs_a_idx;
    logic [pw-1:0]    rs_b_idx;
    logic [pw-1:0]    rd_idx;
    logic [pw-1:0]    wb_idx;
    logic             wb_hit_a;
    logic             wb_hit_b;
    logic             wb_hit_rd;
    logic             hazard;
    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic             unused_ptr_msbs;

    // Pointer bit pw aliases onto the lower half, so only [pw-1:0] indexes busy.
    assign rs_a_idx = bus.in_rs_a[pw-1:0];
    assign rs_b_idx = bus.in_rs_b[pw-1:0];
    assign rd_idx   = bus.in_rd[pw-1:0];
    assign wb_idx   = bus.wb_addr[pw-1:0];
    assign unused_ptr_msbs = bus.wb_addr[pw];

    assign wb_hit_a  = bus.wb_en && (wb_idx == rs_a_idx);
    assign wb_hit_b  = bus.wb_en && (wb_idx == rs_b_idx);
    assign wb_hit_rd = bus.wb_en && (wb_idx == rd_idx);

    assign hazard = (busy[rs_a_idx] && !wb_hit_a) ||
                    (busy[rs_b_idx] && !wb_hit_b) ||
                    (bus.in_wr_en && busy[rd_idx] && !wb_hit_rd);

    assign in_ready = !hazard && (!out_valid_q || bus.out_ready);
    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;

    // A new reservation overrides a release of the same register.
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en) busy_nxt[wb_idx] = 1'b0;
        if (in_xfer && bus.in_wr_en) busy_nxt[rd_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_opa_q   <= '0;
            out_opb_q   <= '0;
            out_rd_q    <= '0;
            out_wr_en_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            busy <= busy_nxt;
            if (in_xfer) begin
                out_valid_q <= 1'b1;
                out_op_q    <= bus.in_op;
                out_opa_q   <= wb_hit_a ? bus.wb_data : bus.rf_datA;
                out_opb_q   <= wb_hit_b ? bus.wb_data : bus.rf_datB;
                out_rd_q    <= bus.in_rd;
                out_wr_en_q <= bus.in_wr_en;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
            if (bus.in_valid && hazard && (stall_q != 8'hFF))
                stall_q <= stall_q + 8'd1;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.rf_rd_addrA = bus.in_rs_a;
    assign bus.rf_rd_addrB = bus.in_rs_b;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_opA     = out_opa_q;
    assign bus.out_opB     = out_opb_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_wr_en   = out_wr_en_q;
    assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table for plain/bypassed fetches,
// hand-written sequences for stalls, backpressure, aliasing and reset.
module tb_operand_fetch;
    localparam int pw = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    operand_fetch_if #(.pw(pw)) bus ();

    operand_fetch #(.pw(pw)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [4:0] rs_a;
        logic [4:0] rs_b;
        logic [4:0] rd;
        logic       we;
        logic [7:0] da;
        logic [7:0] db;
        logic       wb;
        logic [4:0] wba;
        logic [7:0] wbd;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rs_a,
                                input logic [4:0] rs_b, input logic [4:0] rd,
                                input logic we, input logic [7:0] da,
                                input logic [7:0] db, input logic wb,
                                input logic [4:0] wba, input logic [7:0] wbd,
                                input logic [7:0] ea, input logic [7:0] eb);
        vec_t v;
        v.op = op; v.rs_a = rs_a; v.rs_b = rs_b; v.rd = rd; v.we = we;
        v.da = da; v.db = db; v.wb = wb; v.wba = wba; v.wbd = wbd;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_instr(input logic v, input logic [3:0] op,
                             input logic [4:0] rs_a, input logic [4:0] rs_b,
                             input logic [4:0] rd, input logic we,
                             input logic [7:0] da, input logic [7:0] db);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_rs_a  = rs_a;
        bus.in_rs_b  = rs_b;
        bus.in_rd    = rd;
        bus.in_wr_en = we;
        bus.rf_datA  = da;
        bus.rf_datB  = db;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] addr,
                          input logic [7:0] data);
        bus.wb_en   = en;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic idle();
        set_instr(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 8'd0, 8'd0);
        set_wb(1'b0, 5'd0, 8'd0);
    endtask

    task automatic check_bundle(input string tag, input vec_t v);
        check({tag, ".out_valid"}, bus.out_valid, 1);
        check({tag, ".out_op"},    bus.out_op, v.op);
        check({tag, ".out_opA"},   bus.out_opA, v.ea);
        check({tag, ".out_opB"},   bus.out_opB, v.eb);
        check({tag, ".out_rd"},    bus.out_rd, v.rd);
        check({tag, ".out_wr_en"}, bus.out_wr_en, v.we);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.out_ready = 1'b1;
        idle();

        vecs[0] = mk(4'd3, 5'd1,    5'd2,    5'd0,    1'b0, 8'h11, 8'h22, 1'b0, 5'd0,  8'h00, 8'h11, 8'h22);
        vecs[1] = mk(4'd7, 5'd4,    5'd5,    5'd9,    1'b1, 8'h3C, 8'h4D, 1'b0, 5'd0,  8'h00, 8'h3C, 8'h4D);
        vecs[2] = mk(4'd1, 5'h12,   5'd6,    5'h13,   1'b0, 8'h99, 8'h66, 1'b1, 5'd2,  8'h5C, 8'h5C, 8'h66);
        vecs[3] = mk(4'hF, 5'd0,    5'h17,   5'd10,   1'b1, 8'h01, 8'h02, 1'b1, 5'd9,  8'hEE, 8'h01, 8'h02);
        vecs[4] = mk(4'd8, 5'd9,    5'd3,    5'd0,    1'b0, 8'h77, 8'h88, 1'b1, 5'd10, 8'h42, 8'h77, 8'h88);

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            set_instr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   8'($urandom_range(0, 255)));
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst.out_valid", bus.out_valid, 0);
            check("rst.stall_cnt", bus.stall_cnt, 0);
            check("rst.in_ready",  bus.in_ready, 1);
            check("rst.out_opA",   bus.out_opA, 0);
        end
        @(negedge clk);
        idle();
        bus.out_ready = 1'b1;
        rst_n = 1'b1;

        // Table: back-to-back independent and bypassed fetches
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) check_bundle($sformatf("vec%0d", i - 1), vecs[i - 1]);
            set_instr(1'b1, vecs[i].op, vecs[i].rs_a, vecs[i].rs_b, vecs[i].rd,
                      vecs[i].we, vecs[i].da, vecs[i].db);
            set_wb(vecs[i].wb, vecs[i].wba, vecs[i].wbd);
            #1;
            check($sformatf("vec%0d.in_ready", i), bus.in_ready, 1);
            check($sformatf("vec%0d.rf_rd_addrA", i), bus.rf_rd_addrA, vecs[i].rs_a);
            check($sformatf("vec%0d.rf_rd_addrB", i), bus.rf_rd_addrB, vecs[i].rs_b);
        end
        @(negedge clk);
        check_bundle("vec4", vecs[4]);
        idle();
        @(negedge clk);
        check("b2b.drain_valid", bus.out_valid, 0);
        check("b2b.stall_cnt",   bus.stall_cnt, 0);

        // RAW: producer to r5, consumer stalls until write-back
        set_instr(1'b1, 4'd2, 5'd0, 5'd0, 5'd5, 1'b1, 8'h00, 8'h00);
        #1 check("raw.prod_ready", bus.in_ready, 1);
        @(negedge clk);
        set_instr(1'b1, 4'd4, 5'd5, 5'd1, 5'd0, 1'b0, 8'h33, 8'h44);
        for (int c = 0; c < 3; c++) begin
            #1 check($sformatf("raw.stall%0d", c), bus.in_ready, 0);
            @(negedge clk);
        end
        set_wb(1'b1, 5'd5, 8'hA5);
        #1 check("raw.wb_ready", bus.in_ready, 1);
        @(negedge clk);
        check("raw.out_op",    bus.out_op, 4'd4);
        check("raw.out_opA",   bus.out_opA, 8'hA5);
        check("raw.out_opB",   bus.out_opB, 8'h44);
        check("raw.stall_cnt", bus.stall_cnt, 3);
        idle();

        // Backpressure: held bundle, then simultaneous drain and capture
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_instr(1'b1, 4'd6, 5'd1, 5'd2, 5'd0, 1'b0, 8'h10, 8'h20);
        @(negedge clk);
        set_instr(1'b1, 4'd9, 5'd3, 5'd4, 5'd0, 1'b0, 8'h30, 8'h40);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp.in_ready%0d", c),  bus.in_ready, 0);
            check($sformatf("bp.out_valid%0d", c), bus.out_valid, 1);
            check($sformatf("bp.out_op%0d", c),    bus.out_op, 4'd6);
            check($sformatf("bp.out_opA%0d", c),   bus.out_opA, 8'h10);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 check("bp.release_ready", bus.in_ready, 1);
        @(negedge clk);
        check("bp.new_valid", bus.out_valid, 1);
        check("bp.new_op",    bus.out_op, 4'd9);
        check("bp.new_opA",   bus.out_opA, 8'h30);
        check("bp.new_opB",   bus.out_opB, 8'h40);
        check("bp.stall_cnt", bus.stall_cnt, 3);
        idle();

        // Scoreboard: set beats clear on r7, then aliased pointer 0x17 stalls
        @(negedge clk);
        set_instr(1'b1, 4'd5, 5'd0, 5'd0, 5'd7, 1'b1, 8'h00, 8'h00);
        #1 check("sb.first_ready", bus.in_ready, 1);
        @(negedge clk);
        set_instr(1'b1, 4'd6, 5'd0, 5'd0, 5'd7, 1'b1, 8'h00, 8'h00);
        set_wb(1'b1, 5'd7, 8'h31);
        #1 check("sb.waw_bypass_ready", bus.in_ready, 1);
        @(negedge clk);
        set_wb(1'b0, 5'd0, 8'h00);
        set_instr(1'b1, 4'hA, 5'h17, 5'd0, 5'd0, 1'b0, 8'h55, 8'h00);
        #1 check("sb.alias_stall", bus.in_ready, 0);
        set_wb(1'b1, 5'd7, 8'h7E);
        #1 check("sb.alias_wb_ready", bus.in_ready, 1);
        @(negedge clk);
        check("sb.out_op",  bus.out_op, 4'hA);
        check("sb.out_opA", bus.out_opA, 8'h7E);
        idle();

        // Reset during stall and backpressure
        @(negedge clk);
        set_instr(1'b1, 4'd2, 5'd0, 5'd0, 5'd3, 1'b1, 8'h00, 8'h00);
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_instr(1'b1, 4'd1, 5'd3, 5'd0, 5'd0, 1'b0, 8'hC3, 8'h3C);
        #1 check("rm.stall", bus.in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rm.out_valid", bus.out_valid, 0);
        check("rm.out_op",    bus.out_op, 0);
        check("rm.out_rd",    bus.out_rd, 0);
        check("rm.out_wr_en", bus.out_wr_en, 0);
        check("rm.stall_cnt", bus.stall_cnt, 0);
        check("rm.in_ready",  bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1 check("rm.r3_ready", bus.in_ready, 1);
        @(negedge clk);
        check("rm.r3_opA",   bus.out_opA, 8'hC3);
        check("rm.r3_stall", bus.stall_cnt, 0);
        idle();

        // Stall counter saturation
        @(negedge clk);
        set_instr(1'b1, 4'd2, 5'd0, 5'd0, 5'd1, 1'b1, 8'h00, 8'h00);
        @(negedge clk);
        set_instr(1'b1, 4'd3, 5'd1, 5'd0, 5'd0, 1'b0, 8'h00, 8'h00);
        repeat (254) @(negedge clk);
        check("sat.254", bus.stall_cnt, 254);
        repeat (6) @(negedge clk);
        check("sat.255", bus.stall_cnt, 255);
        set_wb(1'b1, 5'd1, 8'h66);
        @(negedge clk);
        check("sat.release_opA", bus.out_opA, 8'h66);
        check("sat.hold",        bus.stall_cnt, 255);
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
